// File: rtl/saida_bcd_seq_if.sv
// Interface bundling the OUT-instruction request and the BCD display results
// of saida_bcd_seq. The master drives the operand and start request; the
// slave (the converter) returns status and the four held BCD digits.
interface saida_bcd_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] entrada_modulo;
    logic                  sinal_out;
    logic                  busy;
    logic                  valid;
    logic                  negativo;
    logic                  overflow;
    logic [3:0]            dp1;
    logic [3:0]            dp2;
    logic [3:0]            dp3;
    logic [3:0]            dp4;

    modport master (
        output entrada_modulo,
        output sinal_out,
        input  busy,
        input  valid,
        input  negativo,
        input  overflow,
        input  dp1,
        input  dp2,
        input  dp3,
        input  dp4
    );

    modport slave (
        input  entrada_modulo,
        input  sinal_out,
        output busy,
        output valid,
        output negativo,
        output overflow,
        output dp1,
        output dp2,
        output dp3,
        output dp4
    );
endinterface

// File: rtl/saida_bcd_seq.sv
// saida_bcd_seq: captures the register value of an OUT instruction and turns
// its magnitude into four BCD digits with a serial shift-add-3 converter.
// Magnitudes above MAX_VAL saturate the display to 9999 and raise overflow.
// Optional macro SAIDA_PEND_EN adds a one-deep slot that queues a request
// arriving during a conversion and chains it directly after the current one.
module saida_bcd_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int DIGITS     = 4,
    parameter int SHIFT_BITS = 14,
    parameter int MAX_VAL    = 9999
) (
    input  logic          clock,
    input  logic          reset,
    saida_bcd_seq_if.slave bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SHIFT_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SHIFT_BITS-1:0] shreg;
    logic [BCD_W-1:0]      bcd;
    logic [CNT_W-1:0]      cnt;
    logic                  sgn;
    logic                  ovf;

    logic                  busy_r;
    logic                  valid_r;
    logic                  neg_r;
    logic                  ovf_r;
    logic [BCD_W-1:0]      digits_r;

    // start request and the operand it loads (from the bus or the pending slot)
    logic                         start_req;
    logic signed [DATA_WIDTH-1:0] start_val;
    logic [DATA_WIDTH-1:0]        start_mag;

    // per-state control derived from the FSM
    logic load_en;
    logic shift_en;
    logic commit_en;
    logic busy_nxt;

`ifdef SAIDA_PEND_EN
    logic                  pend_vld;
    logic [DATA_WIDTH-1:0] pend_val;
`endif

    // Magnitude of a two's-complement value; 0x80000000 stays 2^31 as unsigned.
    function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic signed [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] u;
        u = v;
        if (v[DATA_WIDTH-1])
            return ~u + DATA_WIDTH'(1);
        return u;
    endfunction

    // Correction step of double-dabble: any nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Saturation: an out-of-range magnitude shows all nines.
    function automatic logic [BCD_W-1:0] sat_digits(input logic [BCD_W-1:0] b, input logic o);
        logic [BCD_W-1:0] r;
        r = b;
        if (o) begin
            for (int i = 0; i < DIGITS; i++)
                r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Decide whether a conversion starts this edge and with which operand.
    always_comb begin
        start_req = 1'b0;
        start_val = bus.entrada_modulo;
        case (state)
            IDLE: start_req = bus.sinal_out;
`ifdef SAIDA_PEND_EN
            // A request on the DONE edge itself is newer than any queued one.
            DONE: begin
                if (bus.sinal_out) begin
                    start_req = 1'b1;
                    start_val = bus.entrada_modulo;
                end else if (pend_vld) begin
                    start_req = 1'b1;
                    start_val = pend_val;
                end
            end
`endif
            default: start_req = 1'b0;
        endcase
    end

    assign start_mag = abs_mag(start_val);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_req) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(SHIFT_BITS - 1)) state_nxt = DONE;
            DONE:    state_nxt = start_req ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode for the current state.
    always_comb begin
        load_en   = 1'b0;
        shift_en  = 1'b0;
        commit_en = 1'b0;
        case (state)
            IDLE:  load_en = start_req;
            SHIFT: shift_en = 1'b1;
            DONE: begin
                commit_en = 1'b1;
                load_en   = start_req;
            end
            default: load_en = 1'b0;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // Converter datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sgn      <= 1'b0;
            ovf      <= 1'b0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
            digits_r <= '0;
        end else begin
            busy_r  <= busy_nxt;
            valid_r <= commit_en;

            if (load_en) begin
                shreg <= start_mag[SHIFT_BITS-1:0];
                bcd   <= '0;
                cnt   <= '0;
                sgn   <= start_val[DATA_WIDTH-1];
                ovf   <= (start_mag > DATA_WIDTH'(MAX_VAL));
            end else if (shift_en) begin
                {bcd, shreg} <= {add3(bcd), shreg} << 1;
                cnt          <= cnt + CNT_W'(1);
            end

            // Commit reads the finished accumulator before any chained reload.
            if (commit_en) begin
                digits_r <= sat_digits(bcd, ovf);
                neg_r    <= sgn;
                ovf_r    <= ovf;
            end
        end
    end

`ifdef SAIDA_PEND_EN
    // Pending slot: captures requests made mid-conversion; DONE always drains it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_vld <= 1'b0;
            pend_val <= '0;
        end else if (state == SHIFT && bus.sinal_out) begin
            pend_vld <= 1'b1;
            pend_val <= bus.entrada_modulo;
        end else if (state == DONE) begin
            pend_vld <= 1'b0;
        end
    end
`endif

    assign bus.busy     = busy_r;
    assign bus.valid    = valid_r;
    assign bus.negativo = neg_r;
    assign bus.overflow = ovf_r;
    assign bus.dp1      = digits_r[3:0];
    assign bus.dp2      = digits_r[7:4];
    assign bus.dp3      = digits_r[11:8];
    assign bus.dp4      = digits_r[15:12];

endmodule

// File: tb/tb_saida_bcd_seq.sv
// Directed testbench for saida_bcd_seq with hand-computed expected digits.
module tb_saida_bcd_seq;

    logic clock;
    logic reset;

    int vectors;
    int miscompares;
    logic [15:0] prev_d;

    saida_bcd_seq_if #(.DATA_WIDTH(32)) bus ();

    saida_bcd_seq #(
        .DATA_WIDTH(32),
        .DIGITS(4),
        .SHIFT_BITS(14),
        .MAX_VAL(9999)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {bus.dp4, bus.dp3, bus.dp2, bus.dp1};
    endfunction

    // One full conversion: request at E0, checks busy window, held digits and result.
    task automatic run_conv(input string tag, input logic [31:0] val, input logic [15:0] exp_d,
                            input logic exp_neg, input logic exp_ovf);
        int nb;
        int nv;
        @(negedge clock);
        bus.entrada_modulo = val;
        bus.sinal_out      = 1'b1;
        @(negedge clock);
        bus.sinal_out      = 1'b0;
        bus.entrada_modulo = 32'h5A5A5A5A;
        nb = 0;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.busy === 1'b1) nb++;
            if (bus.valid === 1'b1) nv++;
            if (i < 14) @(negedge clock);
        end
        chk({tag, "_busy_run"}, nb, 15);
        chk({tag, "_valid_early"}, nv, 0);
        chk({tag, "_hold_mid"}, digits(), prev_d);
        @(negedge clock);
        chk({tag, "_valid"}, bus.valid, 1);
        chk({tag, "_busy_end"}, bus.busy, 0);
        chk({tag, "_digits"}, digits(), exp_d);
        chk({tag, "_neg"}, bus.negativo, exp_neg);
        chk({tag, "_ovf"}, bus.overflow, exp_ovf);
        @(negedge clock);
        chk({tag, "_valid_drop"}, bus.valid, 0);
        chk({tag, "_digits_hold"}, digits(), exp_d);
        prev_d = exp_d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int nb;
        int nv;
        vectors            = 0;
        miscompares        = 0;
        prev_d             = 16'h0000;
        reset              = 1'b0;
        bus.sinal_out      = 1'b0;
        bus.entrada_modulo = 32'd0;

        // 1. reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_neg", bus.negativo, 0);
        chk("rst_ovf", bus.overflow, 0);

        // 2. basic conversion
        run_conv("v1234", 32'd1234, 16'h1234, 1'b0, 1'b0);

        // 3. negative and zero
        run_conv("vm42", 32'hFFFFFFD6, 16'h0042, 1'b1, 1'b0);
        run_conv("v0", 32'd0, 16'h0000, 1'b0, 1'b0);

        // 4. saturation boundaries
        run_conv("v10000", 32'd10000, 16'h9999, 1'b0, 1'b1);
        run_conv("vmin", 32'h80000000, 16'h9999, 1'b1, 1'b1);
        run_conv("v9999", 32'd9999, 16'h9999, 1'b0, 1'b0);

        // 5. request during a conversion
        @(negedge clock);
        bus.entrada_modulo = 32'd5678;
        bus.sinal_out      = 1'b1;
        @(negedge clock);
        bus.sinal_out = 1'b0;
        repeat (4) @(negedge clock);
        bus.entrada_modulo = 32'd11;
        bus.sinal_out      = 1'b1;
        @(negedge clock);
        bus.sinal_out      = 1'b0;
        bus.entrada_modulo = 32'd0;
        nv = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (bus.valid === 1'b1) nv++;
        end
        chk("ovl_valid_early", nv, 0);
        @(negedge clock);
        chk("ovl_first_digits", digits(), 16'h5678);
        chk("ovl_first_valid", bus.valid, 1);
`ifdef SAIDA_PEND_EN
        chk("ovl_busy_chain", bus.busy, 1);
        nb = 0;
        nv = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b1) nb++;
            if (bus.valid === 1'b1) nv++;
        end
        chk("ovl_busy_run", nb, 14);
        chk("ovl_valid_mid", nv, 0);
        chk("ovl_hold_mid", digits(), 16'h5678);
        @(negedge clock);
        chk("ovl_second_digits", digits(), 16'h0011);
        chk("ovl_second_valid", bus.valid, 1);
        chk("ovl_second_busy", bus.busy, 0);
        prev_d = 16'h0011;
`else
        chk("ovl_busy_drop", bus.busy, 0);
        nb = 0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b1) nb++;
            if (bus.valid === 1'b1) nv++;
        end
        chk("ovl_no_busy", nb, 0);
        chk("ovl_no_valid", nv, 0);
        chk("ovl_digits_hold", digits(), 16'h5678);
        prev_d = 16'h5678;
`endif

        // 6. reset in the middle of a conversion, with a request on the reset edge
        @(negedge clock);
        bus.entrada_modulo = 32'd4321;
        bus.sinal_out      = 1'b1;
        @(negedge clock);
        bus.sinal_out = 1'b0;
        repeat (6) @(negedge clock);
        reset         = 1'b0;
        bus.sinal_out = 1'b1;
        @(negedge clock);
        reset         = 1'b1;
        bus.sinal_out = 1'b0;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_digits", digits(), 16'h0000);
        chk("mrst_valid", bus.valid, 0);
        chk("mrst_neg", bus.negativo, 0);
        nb = 0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b1) nb++;
            if (bus.valid === 1'b1) nv++;
        end
        chk("mrst_no_busy", nb, 0);
        chk("mrst_no_valid", nv, 0);
        prev_d = 16'h0000;
        run_conv("v77", 32'd77, 16'h0077, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
